// File: rtl/md_ctrl.sv
// Multiply/divide controller: owns HI/LO, runs mult/mthi/mtlo in one cycle and
// sequences the signed/unsigned divider IPs. Optional macro: MD_DIV_ZERO_FAST_EN.
module md_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [5:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    output logic        req_ready,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_tvalid,
    output logic        divu_tvalid,
    input  logic        div_tready,
    input  logic        divu_tready,
    input  logic        div_dout_tvalid,
    input  logic        divu_dout_tvalid,
    input  logic [63:0] div_dout,
    input  logic [63:0] divu_dout,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] dividend_q, dividend_d, divisor_q, divisor_d;
    logic        sgn_q, sgn_d;
    logic        tvalid_q, tvalid_d;
    logic        flush_pend_q, flush_pend_d;

    logic op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo;
    assign {op_mult, op_multu, op_div, op_divu, op_mthi, op_mtlo} = req_op;

    // Sign-extend to 33 bits only for mult; low 64 bits of the product suffice.
    logic signed [32:0] mul_a, mul_b;
    logic signed [63:0] prod;
    assign mul_a = {op_mult & req_src1[31], req_src1};
    assign mul_b = {op_mult & req_src2[31], req_src2};
    assign prod  = mul_a * mul_b;

    logic        sel_tready, sel_dout_v;
    logic [63:0] sel_dout;
    assign sel_tready = sgn_q ? div_tready      : divu_tready;
    assign sel_dout_v = sgn_q ? div_dout_tvalid : divu_dout_tvalid;
    assign sel_dout   = sgn_q ? div_dout        : divu_dout;

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        dividend_d   = dividend_q;
        divisor_d    = divisor_q;
        sgn_d        = sgn_q;
        tvalid_d     = tvalid_q;
        flush_pend_d = flush_pend_q;
        req_ready    = 1'b0;
        case (state_q)
            IDLE: begin
                flush_pend_d = 1'b0;
                if (req_valid && !flush) begin
                    if (op_mult || op_multu) begin
                        req_ready = 1'b1;
                        hi_d      = prod[63:32];
                        lo_d      = prod[31:0];
                    end else if (op_mthi) begin
                        req_ready = 1'b1;
                        hi_d      = req_src1;
                    end else if (op_mtlo) begin
                        req_ready = 1'b1;
                        lo_d      = req_src1;
                    end else if (op_div || op_divu) begin
`ifdef MD_DIV_ZERO_FAST_EN
                        if (req_src2 == 32'd0) begin
                            req_ready = 1'b1;
                            lo_d      = 32'hFFFF_FFFF;
                            hi_d      = req_src1;
                        end else begin
                            dividend_d = req_src1;
                            divisor_d  = req_src2;
                            sgn_d      = op_div;
                            tvalid_d   = 1'b1;
                            state_d    = ISSUE;
                        end
`else
                        dividend_d = req_src1;
                        divisor_d  = req_src2;
                        sgn_d      = op_div;
                        tvalid_d   = 1'b1;
                        state_d    = ISSUE;
`endif
                    end
                end
            end
            ISSUE: begin
                // A flush here must not drop tvalid mid-handshake; remember it.
                if (flush) flush_pend_d = 1'b1;
                if (sel_tready) begin
                    tvalid_d = 1'b0;
                    state_d  = (flush || flush_pend_q) ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = sel_dout_v ? IDLE : DRAIN;
                end else if (sel_dout_v) begin
                    req_ready = 1'b1;
                    lo_d      = sel_dout[63:32];
                    hi_d      = sel_dout[31:0];
                    state_d   = IDLE;
                end
            end
            DRAIN: begin
                if (sel_dout_v) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            hi_q         <= 32'd0;
            lo_q         <= 32'd0;
            dividend_q   <= 32'd0;
            divisor_q    <= 32'd0;
            sgn_q        <= 1'b0;
            tvalid_q     <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            dividend_q   <= dividend_d;
            divisor_q    <= divisor_d;
            sgn_q        <= sgn_d;
            tvalid_q     <= tvalid_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign hi           = hi_q;
    assign lo           = lo_q;
    assign div_tvalid   = tvalid_q & sgn_q;
    assign divu_tvalid  = tvalid_q & ~sgn_q;
    assign div_dividend = dividend_q;
    assign div_divisor  = divisor_q;

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multiply/divide controller for the MIPS execute stage. Owns the HI/LO register pair and sequences the signed and unsigned divider IPs through their AXI-stream handshakes. Presents a single request/ready handshake to the execute stage and discards in-flight divides on pipeline flush. Sits beside the ALU in the execute stage and replaces ad-hoc divider handshake logic there.

## Interface
Parameters:
- none (widths fixed at 32-bit operands, 64-bit product/quotient-remainder)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_valid  in  1  execute stage holds a valid mult/div/mthi/mtlo
- req_op  in  6  one-hot {mult, multu, div, divu, mthi, mtlo}
- req_src1  in  32  rs / dividend
- req_src2  in  32  rt / divisor
- req_ready  out  1  op completes this cycle; HI/LO update at next edge
- flush  in  1  exception/eret flush; cancels current request
- busy  out  1  FSM not IDLE
- hi, lo  out  32  architectural HI/LO (registered)
- div_tvalid, divu_tvalid  out  1  operand tvalid to signed/unsigned divider (both channels)
- div_tready, divu_tready  in  1  AND of divisor_tready and dividend_tready per IP
- div_dout_tvalid, divu_dout_tvalid  in  1  result valid
- div_dout, divu_dout  in  64  {quotient, remainder}
- div_dividend, div_divisor  out  32  registered operands, shared by both IPs

## Operation
- FSM states: IDLE, ISSUE, WAIT, DRAIN. Reset -> IDLE.
- IDLE, req_valid, op in {mult, multu, mthi, mtlo}, !flush: req_ready=1 combinationally; HI/LO write at next edge.
- mult/multu: 33x33 signed product of {s&src[31], src}; hi=prod[63:32], lo=prod[31:0]. mthi: hi=src1, lo unchanged. mtlo: lo=src1, hi unchanged.
- IDLE, req_valid, op div/divu, !flush: latch src1/src2 and signedness -> ISSUE. req_ready=0.
- ISSUE: assert the selected tvalid (other held 0) until its tready=1. Handshake cycle -> WAIT.
- WAIT: on the selected dout_tvalid: lo=dout[63:32] (quotient), hi=dout[31:0] (remainder), req_ready=1 that cycle -> IDLE.
- flush in IDLE: no HI/LO write, req_ready=0.
- flush in ISSUE: handshake completing this cycle -> DRAIN; otherwise tvalid held until handshake, then DRAIN (no protocol violation).
- flush in WAIT -> DRAIN, unless dout_tvalid in the same cycle -> IDLE, result discarded.
- DRAIN: req_ready=0, no HI/LO write; on dout_tvalid -> IDLE.
- req_valid is ignored outside IDLE. The execute stage holds req_op/src stable until req_ready.
- Simultaneous flush and req_ready conditions: flush wins; no HI/LO write.

## Timing
- Reset values: hi=0, lo=0, req_ready=0, busy=0, div_tvalid=divu_tvalid=0, div_dividend=div_divisor=0.
- mult/multu/mthi/mtlo: 0-cycle handshake; new HI/LO visible on hi/lo 1 cycle after req_ready.
- div: req accepted at cycle 0; tvalid high from cycle 1; WAIT after handshake; req_ready in the cycle dout_tvalid rises. Total latency = 2 + IP latency.
- busy=1 in ISSUE, WAIT, and DRAIN.
- Reset mid-divide: FSM -> IDLE and HI/LO cleared. The divider IP must be held idle by the integrator during reset; a stale dout_tvalid seen in IDLE is ignored.

## Configuration
- MD_DIV_ZERO_FAST_EN defined: a div/divu with src2==0 in IDLE completes in that cycle (req_ready=1) with lo=32'hFFFF_FFFF, hi=src1, and no IP transaction.
- MD_DIV_ZERO_FAST_EN undefined: divide-by-zero goes through the IP like any divide; HI/LO take whatever the IP returns.

## Test plan
- mult src1=0xFFFF_FFFE, src2=3 -> req_ready same cycle; next cycle hi=0xFFFF_FFFF, lo=0xFFFF_FFFA. multu same operands -> hi=0x0000_0002, lo=0xFFFF_FFFA.
- div src1=-7 (0xFFFF_FFF9), src2=2 -> tvalid from cycle 1; tready held low 3 cycles, tvalid must stay high; on dout_tvalid lo=0xFFFF_FFFD, hi=0xFFFF_FFFF, busy returns 0.
- divu 100/7 with flush in WAIT -> DRAIN; dout_tvalid arrives; hi/lo unchanged; next mtlo 0x1234 -> lo=0x1234.
- mthi 0xA5A5_A5A5 with flush in the same cycle -> hi unchanged, req_ready=0.
- reset asserted during WAIT -> next cycle busy=0, hi=lo=0, tvalids=0.
- div src1=5, src2=0 with MD_DIV_ZERO_FAST_EN -> req_ready same cycle, lo=0xFFFF_FFFF, hi=5, div_tvalid never asserted; without the macro -> IP handshake occurs.
